// File: rtl/div_clk_monitor.sv
// Measures high, low and period of an asynchronous divided clock in clk_in cycles,
// and reports duty balance, lock on a stable period, and a stalled-clock timeout.
module div_clk_monitor #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TIMEOUT = 200,
   parameter int unsigned LOCK_N  = 4
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             div_clk,
   output logic [CNT_W:0]   period,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] low_time,
   output logic             meas_valid,
   output logic             duty_ok,
   output logic             locked,
   output logic             timeout
);

   typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

   localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
   localparam logic [3:0]       LockMax    = 4'(LOCK_N);

   state_e           r_state;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_s_d;
   logic [CNT_W-1:0] r_hi_cnt;
   logic [CNT_W-1:0] r_lo_cnt;
   logic [CNT_W-1:0] r_h_cap;
   logic [3:0]       r_lock_cnt;

   logic             w_rise;
   logic             w_fall;
   logic [CNT_W-1:0] w_hi_inc;
   logic [CNT_W-1:0] w_lo_inc;
   logic [CNT_W-1:0] w_diff;
   logic [CNT_W:0]   w_period;
   logic             w_duty;

   assign w_rise   = r_sync2 & ~r_s_d;
   assign w_fall   = ~r_sync2 & r_s_d;
   assign w_hi_inc = (r_hi_cnt == '1) ? r_hi_cnt : r_hi_cnt + CntOne;
   assign w_lo_inc = (r_lo_cnt == '1) ? r_lo_cnt : r_lo_cnt + CntOne;
   assign w_period = {1'b0, r_h_cap} + {1'b0, r_lo_cnt};
   assign w_diff   = (r_h_cap >= r_lo_cnt) ? (r_h_cap - r_lo_cnt) : (r_lo_cnt - r_h_cap);
   assign w_duty   = (w_diff <= CntOne);
   assign locked   = (r_lock_cnt == LockMax);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_s_d   <= 1'b0;
      end else begin
         r_sync1 <= div_clk;
         r_sync2 <= r_sync1;
         r_s_d   <= r_sync2;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_hi_cnt   <= '0;
         r_lo_cnt   <= '0;
         r_h_cap    <= '0;
         r_lock_cnt <= '0;
         period     <= '0;
         high_time  <= '0;
         low_time   <= '0;
         meas_valid <= 1'b0;
         duty_ok    <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_rise) begin
                  r_hi_cnt <= CntOne;
                  r_state  <= StHigh;
               end
            end
            StHigh: begin
               if (w_fall) begin
                  r_h_cap  <= r_hi_cnt;
                  r_lo_cnt <= CntOne;
                  r_state  <= StLow;
               end else if (r_hi_cnt == TimeoutCnt) begin
                  timeout    <= 1'b1;
                  r_lock_cnt <= '0;
                  r_hi_cnt   <= '0;
                  r_lo_cnt   <= '0;
                  r_state    <= StIdle;
               end else begin
                  r_hi_cnt <= w_hi_inc;
               end
            end
            StLow: begin
               if (w_rise) begin
                  high_time  <= r_h_cap;
                  low_time   <= r_lo_cnt;
                  period     <= w_period;
                  duty_ok    <= w_duty;
                  meas_valid <= 1'b1;
                  timeout    <= 1'b0;
                  r_hi_cnt   <= CntOne;
                  r_state    <= StHigh;
                  // Compare against the previous measurement still held in period.
                  if (w_duty && (w_period == period)) begin
                     r_lock_cnt <= (r_lock_cnt >= LockMax) ? LockMax : r_lock_cnt + 4'd1;
                  end else begin
                     r_lock_cnt <= {3'b000, w_duty};
                  end
               end else if (r_lo_cnt == TimeoutCnt) begin
                  timeout    <= 1'b1;
                  r_lock_cnt <= '0;
                  r_hi_cnt   <= '0;
                  r_lo_cnt   <= '0;
                  r_state    <= StIdle;
               end else begin
                  r_lo_cnt <= w_lo_inc;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
